bcd_seg_scan: RTL and testbench

- Downstream display stage for the 16-bit BCD counter.
- Takes the packed 4-digit BCD count and drives a time-multiplexed 4-digit common-anode seven-segment display.
- Each frame it snapshots the input so a frame never tears, decodes one digit per scan slot, and optionally blanks leading zeros.
- Inserts a short anode-off interval at each digit change to suppress ghosting.

---
 rtl/bcd_disp_pkg.sv | 22 ++
 rtl/bcd_to_7seg.sv | 32 +++
 rtl/bcd_seg_scan.sv | 103 ++++++++++
 tb/tb_bcd_seg_scan.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] ANODE_OFF = 4'hF;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low segment decoder.
// Non-decimal nibbles show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end else begin
      unique case (nib_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with per-frame
// snapshot, leading-zero blanking and anti-ghost anode gap.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        blank_lz_i,
  input  logic [15:0] bcd_i,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_o,
  output logic        frame_o
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic       wrap;
  logic       gap;
  logic       lz;
  logic [3:0] nib;
  logic [6:0] dec_seg;

  assign wrap    = (div_q == DIV_MAX);
  assign frame_o = en_i & wrap & (idx_q == IDX_LAST);
  assign nib     = snap_q[{idx_q, 2'b00} +: 4];

  if (BLANK_CYC == 0) begin : g_nogap
    assign gap = 1'b0;
  end else begin : g_gap
    localparam logic [DIV_W-1:0] GAP_END = DIV_W'(BLANK_CYC);
    assign gap = (div_q < GAP_END);
  end

  // A digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    lz = 1'b0;
    unique case (idx_q)
      2'd1:    lz = (snap_q[15:4] == 12'h000);
      2'd2:    lz = (snap_q[15:8] == 8'h00);
      2'd3:    lz = (snap_q[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
  end

  bcd_to_7seg u_dec (
    .nib_i   (nib),
    .blank_i (blank_lz_i & lz),
    .seg_o   (dec_seg)
  );

  always_comb begin
    div_d  = div_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    seg_d  = SEG_OFF;
    an_d   = ANODE_OFF;
    if (!en_i) begin
      div_d  = '0;
      idx_d  = '0;
      snap_d = bcd_i;
    end else begin
      div_d = wrap ? '0 : div_q + 1'b1;
      idx_d = wrap ? idx_q + 2'd1 : idx_q;
      if (frame_o) snap_d = bcd_i;
      if (!gap) begin
        seg_d = dec_seg;
        an_d  = ~(4'b0001 << idx_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      seg_q  <= SEG_OFF;
      an_q   <= ANODE_OFF;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized bench for bcd_seg_scan against a frame-level
// reference model of the scanned display.
module tb_bcd_seg_scan;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FRAME = 4 * SD;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic [15:0] bcd_i = 16'h0000;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int checks = 0;
  int failures = 0;

  // model: position inside the frame and the value being shown
  int          pos;
  logic [15:0] shown;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;

  bcd_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .blank_lz_i (blank_lz_i),
    .bcd_i      (bcd_i),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .frame_o    (frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic model_reset();
    pos     = 0;
    shown   = 16'h0000;
    exp_seg = 7'h7F;
    exp_an  = 4'hF;
  endtask

  // What the display shows next cycle, then advance the model.
  task automatic model_edge(input logic en, input logic blz,
                            input logic [15:0] bcd);
    int digit;
    int above;
    digit = pos / SD;
    above = int'(shown) >> (4 * digit);
    if (!en || (pos % SD) < BC) begin
      exp_seg = 7'h7F;
      exp_an  = 4'hF;
    end else begin
      exp_an = 4'hF;
      exp_an[digit] = 1'b0;
      if (blz && digit > 0 && above == 0)
        exp_seg = 7'h7F;
      else
        exp_seg = glyph(above % 16);
    end
    if (!en) begin
      pos   = 0;
      shown = bcd;
    end else begin
      if (pos == FRAME - 1) shown = bcd;
      pos = (pos + 1) % FRAME;
    end
  endtask

  task automatic cycle(input logic en, input logic blz,
                       input logic [15:0] bcd);
    en_i       = en;
    blank_lz_i = blz;
    bcd_i      = bcd;
    #1;
    chk("seg", 16'(seg_o), 16'(exp_seg));
    chk("an", 16'(an_o), 16'(exp_an));
    chk("frame", 16'(frame_o), 16'(en && pos == FRAME - 1));
    @(posedge clk_i);
    model_edge(en, blz, bcd);
    @(negedge clk_i);
  endtask

  task automatic run(input int n, input logic en, input logic blz,
                     input logic [15:0] bcd);
    for (int i = 0; i < n; i++) cycle(en, blz, bcd);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
      else if ($urandom_range(0, 9) == 0) v[4*k +: 4] = 4'(($urandom_range(10, 15)));
      else v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    logic        en;
    logic        blz;
    logic [15:0] bcd;
    model_reset();
    @(negedge clk_i);
    #1;
    chk("rst_seg", 16'(seg_o), 16'h007F);
    chk("rst_an", 16'(an_o), 16'h000F);
    chk("rst_frame", 16'(frame_o), 16'h0000);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run(6, 1'b0, 1'b0, 16'h1234);
    run(2 * FRAME + 3, 1'b1, 1'b0, 16'h1234);
    run(SD, 1'b1, 1'b0, 16'h5678);
    run(2 * FRAME, 1'b1, 1'b0, 16'h5678);
    run(2 * FRAME, 1'b1, 1'b1, 16'h0070);
    run(2 * FRAME, 1'b1, 1'b1, 16'h0000);
    run(2 * FRAME, 1'b1, 1'b0, 16'h00A5);
    run(2 * FRAME, 1'b1, 1'b1, 16'h00A5);

    run(6, 1'b1, 1'b0, 16'h9081);
    run(3, 1'b0, 1'b0, 16'h4321);
    run(BC + 4, 1'b1, 1'b0, 16'h8765);

    en  = 1'b1;
    blz = 1'b0;
    bcd = 16'h2468;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 99) < 4) blz = ~blz;
      if ($urandom_range(0, 99) < 6) bcd = rand_bcd();
      cycle(en, blz, bcd);
    end

    run(FRAME + 5, 1'b1, 1'b0, 16'h1357);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_seg", 16'(seg_o), 16'h007F);
    chk("arst_an", 16'(an_o), 16'h000F);
    chk("arst_frame", 16'(frame_o), 16'h0000);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    run(3 * FRAME, 1'b1, 1'b1, 16'h0305);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
